// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit direction counters and a saturating mispredict counter
module branch_target_buffer #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  input  logic              flush_all,
  output logic [CNT_W-1:0]  mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [ADDR_W-1:0]  tgt_q [ENTRIES];
  logic [ADDR_W-1:0]  tgt_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   li, ui;
  logic [TAG_W-1:0]   lt, ut;
  logic               upd_hit;
  logic               unused;
  assign unused = ^{lookup_pc[1:0], upd_pc[1:0]};
  assign li = lookup_pc[IDX_W+1:2];
  assign lt = lookup_pc[ADDR_W-1:IDX_W+2];
  assign ui = upd_pc[IDX_W+1:2];
  assign ut = upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_q[ui] && tag_q[ui] == ut;
  assign pred_hit = !rst && valid_q[li] && tag_q[li] == lt;
  assign pred_taken = pred_hit && ctr_q[li][1];
  assign pred_target = pred_hit ? tgt_q[li] : '0;
  assign mispred_cnt = cnt_q;
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    ctr_d = ctr_q;
    tgt_d = tgt_q;
    if (upd_valid && upd_hit) begin
      ctr_d[ui] = upd_taken ? (ctr_q[ui] == 2'd3 ? 2'd3 : ctr_q[ui] + 2'd1)
                            : (ctr_q[ui] == 2'd0 ? 2'd0 : ctr_q[ui] - 2'd1);
      tgt_d[ui] = upd_taken ? upd_target : tgt_q[ui];
    end else if (upd_valid && upd_taken) begin
      valid_d[ui] = 1'b1;
      tag_d[ui] = ut;
      ctr_d[ui] = 2'd2;
      tgt_d[ui] = upd_target;
    end
    if (flush_all) valid_d = '0;
    cnt_d = cnt_q + CNT_W'(upd_valid && upd_mispred && !(&cnt_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= 2'd1;
        tgt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q <= tag_d;
      ctr_q <= ctr_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed scoreboard bench for branch_target_buffer
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst, pred_hit, pred_taken, upd_valid, upd_taken, upd_mispred, flush_all;
  logic [31:0] lookup_pc, pred_target, upd_pc, upd_target;
  logic [3:0]  mispred_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string       nm;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [3:0]  cnt;
  } exp_t;
  exp_t sb[$];
  branch_target_buffer #(.ADDR_W(32), .ENTRIES(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .flush_all(flush_all), .mispred_cnt(mispred_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk();
    exp_t e;
    e = sb.pop_front();
    checks += 4;
    assert (pred_hit === e.hit) else begin
      errors++;
      $error("FAIL %s hit: observed %b expected %b", e.nm, pred_hit, e.hit);
    end
    assert (pred_taken === e.taken) else begin
      errors++;
      $error("FAIL %s taken: observed %b expected %b", e.nm, pred_taken, e.taken);
    end
    assert (pred_target === e.tgt) else begin
      errors++;
      $error("FAIL %s target: observed %h expected %h", e.nm, pred_target, e.tgt);
    end
    assert (mispred_cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s cnt: observed %0d expected %0d", e.nm, mispred_cnt, e.cnt);
    end
  endtask
  task automatic step(input string nm, input logic r, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic um, input logic fl,
                      input logic eh, input logic et, input logic [31:0] etg,
                      input logic [3:0] ec);
    exp_t e;
    @(negedge clk);
    rst = r;
    lookup_pc = lpc;
    upd_valid = uv;
    upd_pc = upd_pc == upc ? upc : upc;
    upd_taken = ut;
    upd_target = utgt;
    upd_mispred = um;
    flush_all = fl;
    e.nm = nm;
    e.hit = eh;
    e.taken = et;
    e.tgt = etg;
    e.cnt = ec;
    sb.push_back(e);
    #1 chk();
  endtask
  initial begin
    rst = 1'b1;
    lookup_pc = 32'h40;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_mispred = 1'b0;
    flush_all = 1'b0;
    @(posedge clk);
    step("reset",      1, 32'h40,  0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h0,   4'd0);
    step("alloc_pre",  0, 32'h40,  1, 32'h40, 1, 32'h100, 1, 0, 0, 0, 32'h0,   4'd0);
    step("alloc_hit",  0, 32'h40,  0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h100, 4'd1);
    step("alias_tag",  0, 32'h440, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h0,   4'd1);
    step("nt1_c2",     0, 32'h40,  1, 32'h40, 0, 32'h0,   0, 0, 1, 1, 32'h100, 4'd1);
    step("nt2_c1",     0, 32'h40,  1, 32'h40, 0, 32'h0,   0, 0, 1, 0, 32'h100, 4'd1);
    step("nt3_c0",     0, 32'h40,  1, 32'h40, 0, 32'h0,   0, 0, 1, 0, 32'h100, 4'd1);
    step("t1_c0",      0, 32'h40,  1, 32'h40, 1, 32'h100, 0, 0, 1, 0, 32'h100, 4'd1);
    step("t2_c1",      0, 32'h40,  1, 32'h40, 1, 32'h100, 0, 0, 1, 0, 32'h100, 4'd1);
    step("t3_c2",      0, 32'h40,  1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 4'd1);
    step("t4_c3",      0, 32'h40,  1, 32'h40, 1, 32'h100, 0, 0, 1, 1, 32'h100, 4'd1);
    step("sat_c3",     0, 32'h40,  1, 32'h40, 0, 32'h0,   0, 0, 1, 1, 32'h100, 4'd1);
    step("dec_c2",     0, 32'h40,  1, 32'h40, 0, 32'h0,   0, 0, 1, 1, 32'h100, 4'd1);
    step("miss_nt",    0, 32'h40,  1, 32'h80, 0, 32'h0,   0, 0, 1, 0, 32'h100, 4'd1);
    step("no_alloc",   0, 32'h80,  0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h0,   4'd1);
    step("same_cyc",   0, 32'h40,  1, 32'h40, 1, 32'h200, 1, 0, 1, 0, 32'h100, 4'd1);
    step("new_tgt",    0, 32'h43,  0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h200, 4'd2);
    step("nt_keeptgt", 0, 32'h40,  1, 32'h40, 0, 32'h300, 1, 0, 1, 1, 32'h200, 4'd2);
    step("kept_tgt",   0, 32'h40,  0, 32'h0,  0, 32'h0,   0, 0, 1, 0, 32'h200, 4'd3);
    step("flush_upd",  0, 32'h40,  1, 32'h84, 1, 32'h500, 1, 1, 1, 0, 32'h200, 4'd3);
    step("flush_40",   0, 32'h40,  0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h0,   4'd4);
    step("flush_84",   0, 32'h84,  0, 32'h0,  0, 32'h0,   0, 1, 0, 0, 32'h0,   4'd4);
    step("flush_only", 0, 32'h84,  0, 32'h0,  0, 32'h0,   1, 0, 0, 0, 32'h0,   4'd4);
    step("mp_novalid", 0, 32'h84,  0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h0,   4'd4);
    for (int i = 0; i < 20; i++)
      step("sat_run",  0, 32'hC0,  1, 32'h80, 0, 32'h0,   1, 0, 0, 0, 32'h0,   4'(4 + i > 15 ? 15 : 4 + i));
    step("sat_hold",   0, 32'h40,  1, 32'h40, 1, 32'h100, 1, 0, 0, 0, 32'h0,   4'd15);
    step("pre_rst",    0, 32'h40,  0, 32'h0,  0, 32'h0,   0, 0, 1, 1, 32'h100, 4'd15);
    step("in_rst",     1, 32'h40,  1, 32'h40, 1, 32'h700, 1, 0, 0, 0, 32'h0,   4'd15);
    step("post_rst",   0, 32'h40,  0, 32'h0,  0, 32'h0,   0, 0, 0, 0, 32'h0,   4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
